hazard_scheduler: RTL

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

---
 rtl/hazard_pkg.sv | 39 +++
 rtl/forwarding_unit.sv | 37 +++
 rtl/hazard_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
//----------------------------------------------------------------------
// hazard_pkg: scoreboard slot types, FSM states, forwarding codes. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic       valid;
      logic       wb_en;
      logic       mem_read;
      logic       mem_write;
      logic [3:0] dest;
   } slot_t;

   typedef struct packed {
      slot_t      ctl;
      logic [3:0] src1;
      logic [3:0] src2;
      logic       src1_used;
      logic       src2_used;
   } exe_slot_t;

   function automatic logic src_match(input logic used, input logic [3:0] src, input slot_t s);
      return used & s.valid & s.wb_en & (s.dest == src);
   endfunction

endpackage

`default_nettype wire

// File: rtl/forwarding_unit.sv
//----------------------------------------------------------------------
// forwarding_unit: picks EXE operand sources, MEM result over WB. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module forwarding_unit
   import hazard_pkg::*;
(
   input  logic       i_exe_valid,
   input  logic [3:0] i_src1,
   input  logic       i_src1_used,
   input  logic [3:0] i_src2,
   input  logic       i_src2_used,
   input  logic       i_mem_valid,
   input  logic       i_mem_wb_en,
   input  logic [3:0] i_mem_dest,
   input  logic       i_wb_valid,
   input  logic       i_wb_wb_en,
   input  logic [3:0] i_wb_dest,
   output logic [1:0] o_fwd_sel_a,
   output logic [1:0] o_fwd_sel_b
);

   logic w_a_mem, w_a_wb, w_b_mem, w_b_wb;

   // A bubble in EXE carries no operands, so it never selects a bypass.
   assign w_a_mem = i_exe_valid & i_src1_used & i_mem_valid & i_mem_wb_en & (i_mem_dest == i_src1);
   assign w_a_wb  = i_exe_valid & i_src1_used & i_wb_valid  & i_wb_wb_en  & (i_wb_dest  == i_src1);
   assign w_b_mem = i_exe_valid & i_src2_used & i_mem_valid & i_mem_wb_en & (i_mem_dest == i_src2);
   assign w_b_wb  = i_exe_valid & i_src2_used & i_wb_valid  & i_wb_wb_en  & (i_wb_dest  == i_src2);

   assign o_fwd_sel_a = w_a_mem ? FWD_MEM : (w_a_wb ? FWD_WB : FWD_REG);
   assign o_fwd_sel_b = w_b_mem ? FWD_MEM : (w_b_wb ? FWD_WB : FWD_REG);

endmodule

`default_nettype wire

// File: rtl/hazard_scheduler.sv
//----------------------------------------------------------------------
// hazard_scheduler: pipeline stall/flush/forward control; FORWARDING_EN
// enables the bypass network. Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module hazard_scheduler
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [3:0]  src1,
   input  logic [3:0]  src2,
   input  logic        src1_used,
   input  logic        src2_used,
   input  logic [3:0]  id_dest,
   input  logic        id_wb_en,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        branch_taken,
   input  logic        mem_ready,
   output logic        hazard,
   output logic        freeze_if,
   output logic        flush,
   output logic        freeze_all,
   output logic [1:0]  fwd_sel_a,
   output logic [1:0]  fwd_sel_b,
   output logic [15:0] stall_count
);

   state_t    r_state, w_state_nxt;
   exe_slot_t r_exe, w_exe_nxt;
   slot_t     r_mem, r_wb;
   logic [15:0] r_stall;

   logic w_mem_access, w_freeze_all, w_hazard_raw, w_hazard;
   logic w_m1e, w_m2e;
   logic [1:0] w_fwd_a, w_fwd_b;
   logic w_unused;

   assign w_mem_access = r_mem.valid & (r_mem.mem_read | r_mem.mem_write);
   assign w_m1e = src_match(src1_used, src1, r_exe.ctl);
   assign w_m2e = src_match(src2_used, src2, r_exe.ctl);

`ifdef FORWARDING_EN
   // Only a load still in EXE cannot be bypassed in time.
   assign w_hazard_raw = id_valid & r_exe.ctl.mem_read & (w_m1e | w_m2e);

   forwarding_unit u_fwd (
      .i_exe_valid (r_exe.ctl.valid),
      .i_src1      (r_exe.src1),
      .i_src1_used (r_exe.src1_used),
      .i_src2      (r_exe.src2),
      .i_src2_used (r_exe.src2_used),
      .i_mem_valid (r_mem.valid),
      .i_mem_wb_en (r_mem.wb_en),
      .i_mem_dest  (r_mem.dest),
      .i_wb_valid  (r_wb.valid),
      .i_wb_wb_en  (r_wb.wb_en),
      .i_wb_dest   (r_wb.dest),
      .o_fwd_sel_a (w_fwd_a),
      .o_fwd_sel_b (w_fwd_b)
   );
`else
   logic w_m1m, w_m2m;
   assign w_m1m = src_match(src1_used, src1, r_mem);
   assign w_m2m = src_match(src2_used, src2, r_mem);
   assign w_hazard_raw = id_valid & (w_m1e | w_m2e | w_m1m | w_m2m);
   assign w_fwd_a = FWD_REG;
   assign w_fwd_b = FWD_REG;
`endif

   assign w_unused = ^{r_exe, r_wb};

   always_ff @(posedge clk) begin
      if (!rst) r_state <= ST_RUN;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:      if (w_mem_access && !mem_ready) w_state_nxt = ST_MEM_WAIT;
         ST_MEM_WAIT: if (mem_ready) w_state_nxt = ST_RUN;
         default:     w_state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      w_freeze_all = 1'b0;
      case (r_state)
         ST_RUN:      w_freeze_all = w_mem_access & ~mem_ready;
         ST_MEM_WAIT: w_freeze_all = ~mem_ready;
         default:     w_freeze_all = 1'b0;
      endcase
   end

   // A frozen pipeline cannot take a bubble or act on a branch.
   assign w_hazard   = ~w_freeze_all & w_hazard_raw;
   assign hazard     = rst & w_hazard;
   assign freeze_all = rst & w_freeze_all;
   assign freeze_if  = rst & (w_freeze_all | (w_hazard & ~branch_taken));
   assign flush      = rst & ~w_freeze_all & branch_taken;
   assign fwd_sel_a  = rst ? w_fwd_a : FWD_REG;
   assign fwd_sel_b  = rst ? w_fwd_b : FWD_REG;

   always_comb begin
      w_exe_nxt               = '0;
      w_exe_nxt.ctl.valid     = id_valid & ~w_hazard & ~branch_taken;
      w_exe_nxt.ctl.wb_en     = id_wb_en;
      w_exe_nxt.ctl.mem_read  = id_mem_read;
      w_exe_nxt.ctl.mem_write = id_mem_write;
      w_exe_nxt.ctl.dest      = id_dest;
      w_exe_nxt.src1          = src1;
      w_exe_nxt.src2          = src2;
      w_exe_nxt.src1_used     = src1_used;
      w_exe_nxt.src2_used     = src2_used;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_exe <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else if (!w_freeze_all) begin
         r_exe <= w_exe_nxt;
         r_mem <= r_exe.ctl;
         r_wb  <= r_mem;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         r_stall <= '0;
      else if ((w_freeze_all || w_hazard) && (r_stall != 16'hFFFF))
         r_stall <= r_stall + 16'd1;
   end

   assign stall_count = r_stall;

endmodule

`default_nettype wire
